// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit between EX and WB. Holds one op at a
// time, drives a valid/ready data-cache port and presents a held result to WB.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for the next op from EX
//   REQ      | cache request presented, waiting for i_req_ready
//   WAIT_RSP | request accepted, waiting for the cache response / ack
//   DONE     | result presented to WB, waiting for i_wb_ready
module lsu_mem_stage #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_store_data,
  input  logic [4:0]        i_rd,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic              o_req_we,
  output logic [XLEN-1:0]   o_req_addr,
  output logic [XLEN-1:0]   o_req_wdata,
  output logic [STRB_W-1:0] o_req_strb,
  input  logic              i_rsp_valid,
  input  logic [XLEN-1:0]   i_rsp_rdata,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic              o_wb_we,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t state, state_nxt;

  // Latched op fields
  logic            op_load;
  logic            op_store;
  logic            op_unsigned;
  logic [1:0]      op_size;
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_sdata;
  logic [4:0]      op_rd;

  // Held WB result
  logic [XLEN-1:0] wb_data_q;
  logic            wb_we_q;
  logic            mis_q;

  logic              accept;
  logic              in_mem;
  logic              in_misalign;
  logic              in_illegal;
  logic              in_fault;
  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] lane_strb;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   ld_mask;
  logic              ld_msb;
  logic [XLEN-1:0]   ld_val;

  assign accept = i_valid && (state == IDLE);
  assign in_mem = i_is_load || i_is_store;

  always_comb begin
    case (i_size)
      2'd1:    in_misalign = i_addr[0];
      2'd2:    in_misalign = |i_addr[1:0];
      2'd3:    in_misalign = |i_addr[2:0];
      default: in_misalign = 1'b0;
    endcase
  end

  assign in_illegal = (i_size == 2'd3) && (XLEN == 32);
  assign in_fault   = in_misalign || in_illegal;

  assign off = op_addr[OFF_W-1:0];

  always_comb begin
    case (op_size)
      2'd0:    lane_strb = STRB_W'(1'b1);
      2'd1:    lane_strb = STRB_W'(2'b11);
      2'd2:    lane_strb = STRB_W'(4'hF);
      default: lane_strb = '1;
    endcase
  end

  // Load lane extraction and sign/zero extension from the aligned read word
  assign lane = i_rsp_rdata >> {off, 3'b000};

  always_comb begin
    case (op_size)
      2'd0: begin
        ld_mask = XLEN'(8'hFF);
        ld_msb  = lane[7];
      end
      2'd1: begin
        ld_mask = XLEN'(16'hFFFF);
        ld_msb  = lane[15];
      end
      2'd2: begin
        ld_mask = XLEN'(32'hFFFF_FFFF);
        ld_msb  = lane[31];
      end
      default: begin
        ld_mask = '1;
        ld_msb  = lane[XLEN-1];
      end
    endcase
  end

  assign ld_val = (ld_msb && !op_unsigned) ? (lane | ~ld_mask) : (lane & ld_mask);

  always_comb begin
    state_nxt   = state;
    o_ready     = 1'b0;
    o_req_valid = 1'b0;
    o_wb_valid  = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_nxt = (in_mem && !in_fault) ? REQ : DONE;
        end
      end
      REQ: begin
        o_req_valid = 1'b1;
        if (i_req_ready) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (i_rsp_valid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_wb_valid = 1'b1;
        if (i_wb_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields derive only from latched state, so they hold through stalls
  assign o_req_we    = o_req_valid && op_store;
  assign o_req_addr  = o_req_valid ? {op_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign o_req_wdata = o_req_valid ? (op_sdata << {off, 3'b000}) : '0;
  assign o_req_strb  = !o_req_valid ? '0 :
                       op_store     ? (lane_strb << off) : '1;

  assign o_wb_we      = wb_we_q;
  assign o_wb_rd      = op_rd;
  assign o_wb_data    = wb_data_q;
  assign o_misaligned = mis_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      op_load     <= 1'b0;
      op_store    <= 1'b0;
      op_unsigned <= 1'b0;
      op_size     <= 2'd0;
      op_addr     <= '0;
      op_sdata    <= '0;
      op_rd       <= 5'd0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_load     <= i_is_load;
        op_store    <= i_is_store;
        op_unsigned <= i_unsigned;
        op_size     <= i_size;
        op_addr     <= i_addr;
        op_sdata    <= i_store_data;
        op_rd       <= i_rd;
        mis_q       <= in_mem && in_fault;
        if (!in_mem) begin
          wb_data_q <= i_addr;
          wb_we_q   <= (i_rd != 5'd0);
        end else begin
          wb_data_q <= '0;
          wb_we_q   <= 1'b0;
        end
      end else if ((state == WAIT_RSP) && i_rsp_valid) begin
        wb_data_q <= op_load ? ld_val : '0;
        wb_we_q   <= op_load && (op_rd != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage (XLEN=32): directed scenarios plus randomized ops
// checked against an arithmetic reference model of the load/store rules.
module tb_lsu_mem_stage;
  localparam int XLEN = 32;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_load;
  logic        i_is_store;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd;
  logic        o_req_valid;
  logic        i_req_ready;
  logic        o_req_we;
  logic [31:0] o_req_addr;
  logic [31:0] o_req_wdata;
  logic [3:0]  o_req_strb;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_rdata;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic        o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_misaligned;

  always #5 i_clk = ~i_clk;

  lsu_mem_stage #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_store_data(i_store_data),
    .i_rd(i_rd), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_we(o_req_we), .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
    .o_req_strb(o_req_strb), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_we(o_wb_we),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_misaligned(o_misaligned)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations collected by do_op
  logic        obs_ready0, obs_seen_req, obs_seen_wb, obs_timeout;
  logic        obs_unstable, obs_busy_ready, obs_ready_after;
  logic [31:0] obs_req_addr, obs_req_wdata, obs_wb_data;
  logic [3:0]  obs_req_strb;
  logic        obs_req_we, obs_wb_we, obs_mis;
  logic [4:0]  obs_wb_rd;
  int          obs_lat;

  // Reference model results
  logic        exp_req, exp_req_we, exp_wb_we, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0]  exp_strb;

  task automatic model(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd,
                       input logic [31:0] rdata);
    int n, off;
    logic [63:0] m, v;
    logic mem;
    mem        = ld || st;
    n          = 1 << sz;
    off        = int'(addr % 4);
    exp_mis    = mem && ((sz == 2'd3) || (addr % n != 0));
    exp_req    = mem && !exp_mis;
    exp_addr   = addr - 32'(off);
    exp_req_we = st;
    exp_strb   = st ? 4'(((32'd1 << n) - 1) << off) : 4'hF;
    exp_wdata  = 32'(64'(sdata) << (8 * off));
    if (!mem) begin
      exp_data  = addr;
      exp_wb_we = (rd != 0);
    end else if (exp_mis || st) begin
      exp_data  = 32'd0;
      exp_wb_we = 1'b0;
    end else begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = (64'(rdata) >> (8 * off)) & m;
      if (!uns && v[8*n-1]) v = v | ~m;
      exp_data  = v[31:0];
      exp_wb_we = (rd != 0);
    end
  endtask

  // Drives one op from IDLE through WB completion with the given stall lengths
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd,
                       input logic [31:0] rdata, input int rqw, input int rsw,
                       input int wbw);
    int cyc, rc, sc, wc;
    bit hs, done;
    obs_ready0 = o_ready;
    i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_size = sz;
    i_unsigned = uns; i_addr = addr; i_store_data = sdata; i_rd = rd;
    i_rsp_rdata = rdata;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_size = 2'($urandom); i_unsigned = 1'($urandom); i_addr = $urandom;
    i_store_data = $urandom; i_rd = 5'($urandom);
    obs_seen_req = 0; obs_seen_wb = 0; obs_unstable = 0; obs_busy_ready = 0;
    obs_timeout = 0; obs_lat = 0;
    cyc = 0; rc = 0; sc = 0; wc = 0; hs = 0; done = 0;
    while (!done && cyc < 200) begin
      cyc++;
      i_req_ready = 1'b0; i_rsp_valid = 1'b0; i_wb_ready = 1'b0;
      if (o_ready) obs_busy_ready = 1;
      if (o_req_valid) begin
        if (!obs_seen_req) begin
          obs_seen_req = 1; obs_req_addr = o_req_addr; obs_req_wdata = o_req_wdata;
          obs_req_strb = o_req_strb; obs_req_we = o_req_we;
        end else if (obs_req_addr !== o_req_addr || obs_req_wdata !== o_req_wdata ||
                     obs_req_strb !== o_req_strb || obs_req_we !== o_req_we) begin
          obs_unstable = 1;
        end
        if (rc == rqw) begin i_req_ready = 1'b1; hs = 1; end
        rc++;
      end else if (hs && !o_wb_valid) begin
        if (sc == rsw) i_rsp_valid = 1'b1;
        sc++;
      end
      if (o_wb_valid) begin
        if (!obs_seen_wb) begin
          obs_seen_wb = 1; obs_lat = cyc; obs_wb_data = o_wb_data;
          obs_wb_we = o_wb_we; obs_wb_rd = o_wb_rd; obs_mis = o_misaligned;
        end else if (obs_wb_data !== o_wb_data || obs_wb_we !== o_wb_we ||
                     obs_wb_rd !== o_wb_rd || obs_mis !== o_misaligned) begin
          obs_unstable = 1;
        end
        if (wc == wbw) begin i_wb_ready = 1'b1; done = 1; end
        wc++;
      end
      @(posedge i_clk); #1;
    end
    i_req_ready = 1'b0; i_rsp_valid = 1'b0; i_wb_ready = 1'b0;
    obs_timeout = !done;
    obs_ready_after = o_ready;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_size = 2'd0; i_unsigned = 1'b0; i_addr = 32'd0; i_store_data = 32'd0;
    i_rd = 5'd0; i_req_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_rdata = 32'd0;
    i_wb_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else n_pass++;
    n_checks++;
    if ({o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_req_strb, o_wb_valid,
         o_wb_we, o_wb_rd, o_wb_data, o_misaligned} !== '0)
      $display("FAIL reset_outputs got req_v=%b strb=%h wb_v=%b wb_data=%h rd=%0d mis=%b want all 0",
               o_req_valid, o_req_strb, o_wb_valid, o_wb_data, o_wb_rd, o_misaligned);
    else n_pass++;
    i_reset = 1'b0;
  endtask

  task automatic test_passthrough;
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 32'h0, 0, 0, 0);
    n_checks++; if (obs_timeout) $display("FAIL t1_timeout got timeout want wb"); else n_pass++;
    n_checks++; if (obs_lat !== 1) $display("FAIL t1_latency got %0d want 1", obs_lat); else n_pass++;
    n_checks++; if (obs_wb_data !== 32'hDEADBEEF) $display("FAIL t1_data got %h want deadbeef", obs_wb_data); else n_pass++;
    n_checks++; if (obs_wb_we !== 1'b1 || obs_wb_rd !== 5'd5) $display("FAIL t1_we_rd got we=%b rd=%0d want we=1 rd=5", obs_wb_we, obs_wb_rd); else n_pass++;
    n_checks++; if (obs_seen_req !== 1'b0) $display("FAIL t1_no_req got req seen want none"); else n_pass++;
    do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_1234, 32'h0, 5'd0, 32'h0, 0, 0, 0);
    n_checks++; if (obs_wb_we !== 1'b0 || obs_wb_data !== 32'h1234) $display("FAIL t1_rd0 got we=%b data=%h want we=0 data=00001234", obs_wb_we, obs_wb_data); else n_pass++;
  endtask

  task automatic test_lb_signed;
    do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd7, 32'h80AABBCC, 0, 0, 0);
    n_checks++; if (obs_req_addr !== 32'h1000 || obs_req_we !== 1'b0) $display("FAIL t2_req got addr=%h we=%b want 00001000 we=0", obs_req_addr, obs_req_we); else n_pass++;
    n_checks++; if (obs_req_strb !== 4'hF) $display("FAIL t2_strb got %h want f", obs_req_strb); else n_pass++;
    n_checks++; if (obs_wb_data !== 32'hFFFFFF80) $display("FAIL t2_data got %h want ffffff80", obs_wb_data); else n_pass++;
    n_checks++; if (obs_lat !== 3) $display("FAIL t2_latency got %0d want 3", obs_lat); else n_pass++;
  endtask

  task automatic test_sh;
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234, 5'd9, 32'hFFFF_FFFF, 0, 1, 0);
    n_checks++; if (obs_req_strb !== 4'hC || obs_req_we !== 1'b1) $display("FAIL t3_strb got %h we=%b want c we=1", obs_req_strb, obs_req_we); else n_pass++;
    n_checks++; if (obs_req_wdata !== 32'h12340000) $display("FAIL t3_wdata got %h want 12340000", obs_req_wdata); else n_pass++;
    n_checks++; if (obs_wb_we !== 1'b0 || obs_wb_data !== 32'h0) $display("FAIL t3_wb got we=%b data=%h want we=0 data=0", obs_wb_we, obs_wb_data); else n_pass++;
  endtask

  task automatic test_misaligned;
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd3, 32'h0, 0, 0, 0);
    n_checks++; if (obs_mis !== 1'b1 || obs_wb_we !== 1'b0) $display("FAIL t4_fault got mis=%b we=%b want mis=1 we=0", obs_mis, obs_wb_we); else n_pass++;
    n_checks++; if (obs_seen_req !== 1'b0) $display("FAIL t4_no_req got req seen want none"); else n_pass++;
    n_checks++; if (obs_lat !== 1) $display("FAIL t4_latency got %0d want 1", obs_lat); else n_pass++;
    do_op(1'b0, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 5'd3, 32'h0, 0, 0, 0);
    n_checks++; if (obs_mis !== 1'b1 || obs_seen_req !== 1'b0) $display("FAIL t4_size_d got mis=%b req=%b want mis=1 req=0", obs_mis, obs_seen_req); else n_pass++;
  endtask

  task automatic test_backpressure;
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h5004, 32'hCAFEF00D, 5'd1, 32'h0, 10, 0, 5);
    n_checks++; if (obs_unstable) $display("FAIL t5_store_stable got outputs changed during stall want stable"); else n_pass++;
    n_checks++; if (obs_req_wdata !== 32'hCAFEF00D || obs_req_strb !== 4'hF) $display("FAIL t5_store_req got wdata=%h strb=%h want cafef00d f", obs_req_wdata, obs_req_strb); else n_pass++;
    n_checks++; if (obs_lat !== 13) $display("FAIL t5_latency got %0d want 13", obs_lat); else n_pass++;
    do_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h6006, 32'h0, 5'd2, 32'h8001_0000, 10, 3, 5);
    n_checks++; if (obs_unstable || obs_wb_data !== 32'h00008001) $display("FAIL t5_load got unstable=%b data=%h want 0 00008001", obs_unstable, obs_wb_data); else n_pass++;
  endtask

  task automatic test_reset_wait_rsp;
    bit wb_seen;
    i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_size = 2'd2;
    i_unsigned = 1'b0; i_addr = 32'h4000; i_rd = 5'd4; i_rsp_rdata = 32'h1111_2222;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_is_load = 1'b0; i_req_ready = 1'b1;
    @(posedge i_clk); #1;
    i_req_ready = 1'b0;
    n_checks++; if (o_ready !== 1'b0 || o_req_valid !== 1'b0 || o_wb_valid !== 1'b0) $display("FAIL t6_in_wait got ready=%b req=%b wb=%b want 0 0 0", o_ready, o_req_valid, o_wb_valid); else n_pass++;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL t6_ready_after_reset got %b want 1", o_ready); else n_pass++;
    wb_seen = 0;
    i_rsp_valid = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      if (o_wb_valid || o_req_valid) wb_seen = 1;
    end
    i_rsp_valid = 1'b0;
    n_checks++; if (wb_seen) $display("FAIL t6_late_rsp got wb/req activity want none"); else n_pass++;
    do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'hA5A5_0001, 32'h0, 5'd6, 32'h0, 0, 0, 0);
    n_checks++; if (obs_ready0 !== 1'b1 || obs_wb_data !== 32'hA5A5_0001) $display("FAIL t6_recover got ready=%b data=%h want 1 a5a50001", obs_ready0, obs_wb_data); else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h100 + 32'(k), 32'h0, 5'(k + 10), 32'h0, 0, 0, 0);
      n_checks++; if (obs_ready0 !== 1'b1 || obs_busy_ready !== 1'b0) $display("FAIL b2b_ready_%0d got start=%b busy=%b want 1 0", k, obs_ready0, obs_busy_ready); else n_pass++;
      n_checks++; if (obs_wb_data !== 32'h100 + 32'(k) || obs_wb_rd !== 5'(k + 10)) $display("FAIL b2b_data_%0d got %h rd=%0d want %h rd=%0d", k, obs_wb_data, obs_wb_rd, 32'h100 + 32'(k), k + 10); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic ld, st, uns;
    logic [1:0] sz;
    logic [31:0] addr, sdata, rdata;
    logic [4:0] rd;
    int kind, rqw, rsw, wbw, exp_lat;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2);
      sz = 2'($urandom_range(0, 3)); uns = 1'($urandom);
      addr = $urandom; sdata = $urandom; rdata = $urandom;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 1);
      rqw = $urandom_range(0, 3); rsw = $urandom_range(0, 3); wbw = $urandom_range(0, 3);
      model(ld, st, sz, uns, addr, sdata, rd, rdata);
      exp_lat = exp_req ? 3 + rqw + rsw : 1;
      do_op(ld, st, sz, uns, addr, sdata, rd, rdata, rqw, rsw, wbw);
      n_checks++; if (obs_timeout) $display("FAIL rnd%0d_timeout got no wb want wb", k); else n_pass++;
      n_checks++; if (obs_ready0 !== 1'b1 || obs_busy_ready || obs_ready_after !== 1'b1) $display("FAIL rnd%0d_ready got start=%b busy=%b after=%b want 1 0 1", k, obs_ready0, obs_busy_ready, obs_ready_after); else n_pass++;
      n_checks++; if (obs_seen_req !== exp_req) $display("FAIL rnd%0d_req_seen got %b want %b", k, obs_seen_req, exp_req); else n_pass++;
      if (exp_req && obs_seen_req) begin
        n_checks++; if (obs_req_addr !== exp_addr || obs_req_we !== exp_req_we || obs_req_strb !== exp_strb) $display("FAIL rnd%0d_req got addr=%h we=%b strb=%h want %h %b %h", k, obs_req_addr, obs_req_we, obs_req_strb, exp_addr, exp_req_we, exp_strb); else n_pass++;
        if (st) begin
          n_checks++; if (obs_req_wdata !== exp_wdata) $display("FAIL rnd%0d_wdata got %h want %h", k, obs_req_wdata, exp_wdata); else n_pass++;
        end
      end
      n_checks++; if (obs_unstable) $display("FAIL rnd%0d_stable got outputs changed during stall want stable", k); else n_pass++;
      n_checks++; if (obs_wb_data !== exp_data || obs_wb_we !== exp_wb_we || obs_wb_rd !== rd || obs_mis !== exp_mis) $display("FAIL rnd%0d_wb got data=%h we=%b rd=%0d mis=%b want %h %b %0d %b", k, obs_wb_data, obs_wb_we, obs_wb_rd, obs_mis, exp_data, exp_wb_we, rd, exp_mis); else n_pass++;
      n_checks++; if (obs_lat !== exp_lat) $display("FAIL rnd%0d_latency got %0d want %0d", k, obs_lat, exp_lat); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb_signed();
    test_sh();
    test_misaligned();
    test_backpressure();
    test_reset_wait_rsp();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
